// File: rtl/redstone_tick_sequencer_pkg.sv
// Shared types and board defaults for the redstone tick sequencer.
package redstone_pkg;

  // Host-selected execution mode; encoding 3 is reserved and behaves as STOP.
  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STEP = 2'd2
  } mode_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_SETUP = 2'd1,
    SEQ_HIGH  = 2'd2,
    SEQ_LOW   = 2'd3
  } seq_state_e;

  // 10 Hz redstone tick with 50% duty on a 50 MHz board.
  localparam int unsigned DEF_PERIOD   = 5000000;
  localparam int unsigned DEF_HIGH_CYC = 2500000;
  localparam int unsigned DEF_NUM_IO   = 10;
  localparam int unsigned DEF_CNT_W    = 32;

  // Width of the phase timer; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned period);
    return (period > 2) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/redstone_tick_sequencer_if.sv
// Host/netlist-facing bundle of the tick sequencer.
interface redstone_tick_sequencer_if
  import redstone_pkg::*;
#(
  parameter int unsigned NUM_IO = DEF_NUM_IO,
  parameter int unsigned CNT_W  = DEF_CNT_W
);
  logic [1:0]        i_mode;
  logic              i_step_req;
  logic [15:0]       i_step_n;
  logic [NUM_IO-1:0] i_inputs;
  logic [NUM_IO-1:0] o_inputs;
  logic [NUM_IO-1:0] i_outputs;
  logic [NUM_IO-1:0] o_outputs;
  logic              o_tick;
  logic              o_busy;
  logic              o_done;
  logic [CNT_W-1:0]  o_tick_count;

  // Host / environment side.
  modport master (
    output i_mode, i_step_req, i_step_n, i_inputs, i_outputs,
    input  o_inputs, o_outputs, o_tick, o_busy, o_done, o_tick_count
  );

  // Sequencer side.
  modport slave (
    input  i_mode, i_step_req, i_step_n, i_inputs, i_outputs,
    output o_inputs, o_outputs, o_tick, o_busy, o_done, o_tick_count
  );
endinterface

// File: rtl/redstone_tick_sequencer_tick_timer.sv
// Loadable down-counter that times the HIGH and LOW phases of a tick.
module tick_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  // Reload on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/redstone_tick_sequencer.sv
// Generates the slow redstone tick from the system clock, with free-run,
// stop and N-step bursts, and latches netlist inputs/outputs around it.
module redstone_tick_sequencer
  import redstone_pkg::*;
#(
  // PERIOD must be at least HIGH_CYC+2 and HIGH_CYC at least 1.
  parameter int unsigned PERIOD   = DEF_PERIOD,
  parameter int unsigned HIGH_CYC = DEF_HIGH_CYC,
  parameter int unsigned NUM_IO   = DEF_NUM_IO,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  redstone_tick_sequencer_if.slave bus
);
  localparam int unsigned TMR_W = timer_width(PERIOD);
  // Timer counts load_val..0, so each phase loads its length minus one.
  localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(PERIOD - HIGH_CYC - 2);

  localparam logic [1:0] ST_IDLE  = SEQ_IDLE;
  localparam logic [1:0] ST_SETUP = SEQ_SETUP;
  localparam logic [1:0] ST_HIGH  = SEQ_HIGH;
  localparam logic [1:0] ST_LOW   = SEQ_LOW;

  localparam logic [1:0] M_RUN  = MODE_RUN;
  localparam logic [1:0] M_STEP = MODE_STEP;

  logic [1:0]        state;
  logic              tick_q;
  logic              done_q;
  logic              in_burst;
  logic [15:0]       steps_left;
  logic [CNT_W-1:0]  count_q;
  logic [NUM_IO-1:0] inputs_q;
  logic [NUM_IO-1:0] outputs_q;

  logic              timer_load;
  logic [TMR_W-1:0]  timer_val;
  logic              timer_zero;
  logic              last_low;

  tick_timer #(.W(TMR_W)) u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Reload the timer on entry to HIGH (from SETUP) and to LOW (from HIGH).
  always_comb begin
    timer_load = (state == ST_SETUP) || ((state == ST_HIGH) && timer_zero);
    timer_val  = (state == ST_SETUP) ? HIGH_LOAD : LOW_LOAD;
    last_low   = (state == ST_LOW) && timer_zero;
  end

  // Sequencer FSM: mode is only sampled in IDLE and in the last LOW cycle,
  // so a tick is never truncated by a mode change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      in_burst   <= 1'b0;
      steps_left <= '0;
      count_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_mode == M_RUN) begin
            state    <= ST_SETUP;
            in_burst <= 1'b0;
          end else if ((bus.i_mode == M_STEP) && bus.i_step_req) begin
            steps_left <= bus.i_step_n;
            if (bus.i_step_n == '0) begin
              done_q <= 1'b1;
            end else begin
              state    <= ST_SETUP;
              in_burst <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          state   <= ST_HIGH;
          tick_q  <= 1'b1;
          count_q <= count_q + CNT_W'(1);
        end
        ST_HIGH: begin
          if (timer_zero) begin
            state  <= ST_LOW;
            tick_q <= 1'b0;
          end
        end
        ST_LOW: begin
          if (timer_zero) begin
            if (bus.i_mode == M_RUN) begin
              // A STEP burst switched to RUN is abandoned silently.
              state    <= ST_SETUP;
              in_burst <= 1'b0;
            end else if ((bus.i_mode == M_STEP) && in_burst) begin
              steps_left <= steps_left - 16'd1;
              if (steps_left == 16'd1) begin
                done_q   <= 1'b1;
                state    <= ST_IDLE;
                in_burst <= 1'b0;
              end else begin
                state <= ST_SETUP;
              end
            end else begin
              // STOP, reserved, or STEP entered from RUN: finish quietly.
              state    <= ST_IDLE;
              in_burst <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Netlist I/O latches: inputs change only as tick rises, outputs are
  // captured once the netlist has settled at the end of the low phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inputs_q  <= '0;
      outputs_q <= '0;
    end else begin
      if (state == ST_SETUP) inputs_q  <= bus.i_inputs;
      if (last_low)          outputs_q <= bus.i_outputs;
    end
  end

  assign bus.o_tick       = tick_q;
  assign bus.o_busy       = (state != ST_IDLE);
  assign bus.o_done       = done_q;
  assign bus.o_tick_count = count_q;
  assign bus.o_inputs     = inputs_q;
  assign bus.o_outputs    = outputs_q;
endmodule

// File: tb/tb_redstone_tick_sequencer.sv
// Bench for redstone_tick_sequencer with PERIOD=8, HIGH_CYC=3.
module tb_redstone_tick_sequencer;
  localparam int PERIOD   = 8;
  localparam int HIGH_CYC = 3;
  localparam int NUM_IO   = 10;
  localparam int CNT_W    = 32;
  localparam int VEC_W    = 3 + CNT_W + 2 * NUM_IO;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  redstone_tick_sequencer_if #(.NUM_IO(NUM_IO), .CNT_W(CNT_W)) bus ();

  redstone_tick_sequencer #(
    .PERIOD(PERIOD), .HIGH_CYC(HIGH_CYC), .NUM_IO(NUM_IO), .CNT_W(CNT_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Reference model: position within the tick (0 = setup cycle,
  // 1..HIGH_CYC = tick high, remaining = tick low) plus burst bookkeeping.
  bit               m_active, m_burst, m_done;
  int               m_pos, m_steps;
  logic [CNT_W-1:0]  m_cnt;
  logic [NUM_IO-1:0] m_in, m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_burst = 0; m_done = 0; m_pos = 0; m_steps = 0;
      m_cnt = '0; m_in = '0; m_out = '0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (bus.i_mode == 2'd1) begin
          m_active = 1; m_pos = 0; m_burst = 0;
        end else if (bus.i_mode == 2'd2 && bus.i_step_req) begin
          m_steps = int'(bus.i_step_n);
          if (m_steps == 0) m_done = 1;
          else begin m_active = 1; m_pos = 0; m_burst = 1; end
        end
      end else if (m_pos == 0) begin
        m_in = bus.i_inputs; m_cnt = m_cnt + 1; m_pos = 1;
      end else if (m_pos < PERIOD - 1) begin
        m_pos = m_pos + 1;
      end else begin
        m_out = bus.i_outputs;
        if (bus.i_mode == 2'd1) begin
          m_pos = 0; m_burst = 0;
        end else if (bus.i_mode == 2'd2 && m_burst) begin
          m_steps = m_steps - 1;
          if (m_steps == 0) begin m_done = 1; m_active = 0; m_burst = 0; end
          else m_pos = 0;
        end else begin
          m_active = 0; m_burst = 0;
        end
      end
    end
  end

  function automatic logic [VEC_W-1:0] exp_vec();
    logic t;
    t = m_active && (m_pos >= 1) && (m_pos <= HIGH_CYC);
    return {t, m_active, m_done, m_cnt, m_in, m_out};
  endfunction

  wire [VEC_W-1:0] dut_vec = {bus.o_tick, bus.o_busy, bus.o_done,
                              bus.o_tick_count, bus.o_inputs, bus.o_outputs};

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.i_mode = 2'd0; bus.i_step_req = 1'b0; bus.i_step_n = '0;
    bus.i_inputs = '0; bus.i_outputs = '0;
    rst_n = 1'b0;
    repeat (2) next_cycle();
    if (dut_vec !== '0) begin
      tests_failed++; $display("FAIL reset_outputs got=%h exp=0", dut_vec);
    end
    tests_run++;
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      if ({bus.o_tick, bus.o_busy, bus.o_done} !== 3'b000 || bus.o_tick_count !== '0) begin
        tests_failed++;
        $display("FAIL stop_idle cyc=%0d got tick/busy/done=%b%b%b cnt=%0d exp 000 cnt=0",
                 i, bus.o_tick, bus.o_busy, bus.o_done, bus.o_tick_count);
      end
      tests_run++;
    end
  endtask

  task automatic test_run();
    int rises[$];
    int hi_lens[$];
    int hi_len = 0;
    logic prev = bus.o_tick;
    bus.i_mode = 2'd1;
    for (int i = 1; i <= 40; i++) begin
      next_cycle();
      if (dut_vec !== exp_vec()) begin
        tests_failed++; $display("FAIL run_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      tests_run++;
      if (bus.o_tick && !prev) rises.push_back(i);
      if (bus.o_tick) hi_len++;
      else if (prev) begin hi_lens.push_back(hi_len); hi_len = 0; end
      prev = bus.o_tick;
    end
    if (rises.size() != 5) begin
      tests_failed++; $display("FAIL run_rise_count got=%0d exp=5", rises.size());
    end
    tests_run++;
    for (int k = 1; k < rises.size(); k++) begin
      if (rises[k] - rises[k-1] != PERIOD) begin
        tests_failed++; $display("FAIL run_spacing k=%0d got=%0d exp=%0d", k, rises[k] - rises[k-1], PERIOD);
      end
      tests_run++;
    end
    foreach (hi_lens[k]) begin
      if (hi_lens[k] != HIGH_CYC) begin
        tests_failed++; $display("FAIL run_high_len k=%0d got=%0d exp=%0d", k, hi_lens[k], HIGH_CYC);
      end
      tests_run++;
    end
    if (bus.o_tick_count !== 32'd5) begin
      tests_failed++; $display("FAIL run_count got=%0d exp=5", bus.o_tick_count);
    end
    tests_run++;
    bus.i_mode = 2'd0;
    for (int i = 0; i < PERIOD + 2 && bus.o_busy; i++) next_cycle();
    if (bus.o_busy !== 1'b0 || dut_vec !== exp_vec()) begin
      tests_failed++; $display("FAIL run_drain got=%h exp=%h", dut_vec, exp_vec());
    end
    tests_run++;
  endtask

  task automatic test_step();
    int rises[$];
    int dones[$];
    logic prev = bus.o_tick;
    bus.i_mode = 2'd2; bus.i_step_n = 16'd3; bus.i_step_req = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      next_cycle();
      if (dut_vec !== exp_vec()) begin
        tests_failed++; $display("FAIL step_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      tests_run++;
      if (bus.o_tick && !prev) rises.push_back(i);
      if (bus.o_done) dones.push_back(i);
      prev = bus.o_tick;
      bus.i_step_req = (i == 5);
      bus.i_step_n = (i == 5) ? 16'd5 : 16'd3;
    end
    if (rises.size() != 3 || dones.size() != 1) begin
      tests_failed++; $display("FAIL step_counts got rises=%0d dones=%0d exp 3 and 1", rises.size(), dones.size());
    end else begin
      if (dones[0] - rises[2] != 7) begin
        tests_failed++; $display("FAIL step_done_delay got=%0d exp=7", dones[0] - rises[2]);
      end
      tests_run++;
    end
    tests_run++;
    if (bus.o_busy !== 1'b0 || bus.o_tick_count !== 32'd8) begin
      tests_failed++; $display("FAIL step_end got busy=%b cnt=%0d exp busy=0 cnt=8", bus.o_busy, bus.o_tick_count);
    end
    tests_run++;
  endtask

  task automatic test_step_zero();
    bus.i_mode = 2'd2; bus.i_step_n = 16'd0; bus.i_step_req = 1'b1;
    next_cycle();
    bus.i_step_req = 1'b0;
    if ({bus.o_done, bus.o_tick, bus.o_busy} !== 3'b100 || dut_vec !== exp_vec()) begin
      tests_failed++; $display("FAIL step_zero_done got done/tick/busy=%b%b%b exp 100", bus.o_done, bus.o_tick, bus.o_busy);
    end
    tests_run++;
    next_cycle();
    if ({bus.o_done, bus.o_tick, bus.o_busy} !== 3'b000 || bus.o_tick_count !== 32'd8) begin
      tests_failed++; $display("FAIL step_zero_after got done/tick/busy=%b%b%b cnt=%0d exp 000 cnt=8",
                               bus.o_done, bus.o_tick, bus.o_busy, bus.o_tick_count);
    end
    tests_run++;
  endtask

  task automatic test_io_latch();
    logic [NUM_IO-1:0] prev_in = bus.o_inputs;
    logic prev_tick = bus.o_tick;
    bit chk = 0;
    int hits = 0;
    bus.i_mode = 2'd1;
    for (int i = 1; i <= 30; i++) begin
      next_cycle();
      if (dut_vec !== exp_vec()) begin
        tests_failed++; $display("FAIL io_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      tests_run++;
      if (bus.o_inputs !== prev_in && !(bus.o_tick && !prev_tick)) begin
        tests_failed++; $display("FAIL io_inputs_stable cyc=%0d got=%h prev=%h tick=%b", i, bus.o_inputs, prev_in, bus.o_tick);
      end
      tests_run++;
      if (chk) begin
        if (bus.o_outputs !== 10'h2A3) begin
          tests_failed++; $display("FAIL io_outputs_capture cyc=%0d got=%h exp=2a3", i, bus.o_outputs);
        end
        tests_run++;
        hits++;
      end
      prev_in = bus.o_inputs; prev_tick = bus.o_tick;
      bus.i_inputs = NUM_IO'($urandom);
      chk = m_active && (m_pos == PERIOD - 1);
      if (chk) bus.i_outputs = 10'h2A3;
      else begin
        bus.i_outputs = NUM_IO'($urandom);
        if (bus.i_outputs == 10'h2A3) bus.i_outputs = 10'h2A2;
      end
    end
    if (hits < 3) begin
      tests_failed++; $display("FAIL io_capture_seen got=%0d exp>=3", hits);
    end
    tests_run++;
    bus.i_mode = 2'd0;
    for (int i = 0; i < PERIOD + 2 && bus.o_busy; i++) next_cycle();
    if (bus.o_busy !== 1'b0 || dut_vec !== exp_vec()) begin
      tests_failed++; $display("FAIL io_drain got=%h exp=%h", dut_vec, exp_vec());
    end
    tests_run++;
  endtask

  task automatic test_stop_mid();
    int hi = 0;
    int elapsed = 0;
    bit seen = 0;
    bus.i_mode = 2'd1;
    for (int i = 0; i < 20 && !seen; i++) begin
      next_cycle();
      seen = bus.o_tick;
    end
    if (!seen) begin
      tests_failed++; $display("FAIL stop_mid_rise got no rise within 20 cycles exp rise");
    end
    tests_run++;
    hi = 1;
    next_cycle();
    elapsed = 1;
    if (bus.o_tick) hi++;
    bus.i_mode = 2'd0;
    for (int i = 0; i < 12 && bus.o_busy; i++) begin
      next_cycle();
      elapsed++;
      if (bus.o_tick) hi++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++; $display("FAIL stop_mid_model got=%h exp=%h", dut_vec, exp_vec());
      end
      tests_run++;
    end
    if (hi != HIGH_CYC || elapsed != PERIOD - 1 || bus.o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL stop_mid_tick got high=%0d idle_after=%0d busy=%b exp high=3 idle_after=7 busy=0",
                               hi, elapsed, bus.o_busy);
    end
    tests_run++;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    bus.i_mode = 2'd1;
    for (int i = 0; i < 20 && !seen; i++) begin
      next_cycle();
      seen = bus.o_tick;
    end
    next_cycle();
    if (bus.o_tick !== 1'b1) begin
      tests_failed++; $display("FAIL reset_mid_high got tick=%b exp 1", bus.o_tick);
    end
    tests_run++;
    rst_n = 1'b0;
    #1;
    if (dut_vec !== '0) begin
      tests_failed++; $display("FAIL reset_mid_async got=%h exp=0", dut_vec);
    end
    tests_run++;
    bus.i_mode = 2'd0;
    @(negedge clk);
    next_cycle();
    rst_n = 1'b1;
    repeat (3) next_cycle();
    if (bus.o_tick_count !== '0 || dut_vec !== exp_vec()) begin
      tests_failed++; $display("FAIL reset_mid_release got cnt=%0d vec=%h exp cnt=0 vec=%h",
                               bus.o_tick_count, dut_vec, exp_vec());
    end
    tests_run++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) bus.i_mode = 2'($urandom_range(0, 3));
      bus.i_step_req = ($urandom_range(0, 7) == 0);
      bus.i_step_n   = 16'($urandom_range(0, 3));
      bus.i_inputs   = NUM_IO'($urandom);
      bus.i_outputs  = NUM_IO'($urandom);
      next_cycle();
      if (dut_vec !== exp_vec()) begin
        tests_failed++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      tests_run++;
    end
    bus.i_mode = 2'd0; bus.i_step_req = 1'b0;
    for (int i = 0; i < 4 * PERIOD && bus.o_busy; i++) next_cycle();
    if (bus.o_busy !== 1'b0 || dut_vec !== exp_vec()) begin
      tests_failed++; $display("FAIL random_drain got=%h exp=%h", dut_vec, exp_vec());
    end
    tests_run++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_step_zero();
    test_io_latch();
    test_stop_mid();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/redstone_tick_sequencer.md
Name: redstone_tick_sequencer

Overview:
Generates and sequences the redstone `tick` that clocks the compiled `redstone` netlist (repeater cells) from the fast system clock. Supports free-run, pause and N-step execution. Latches the external inputs so they change only while tick is low. Captures the netlist outputs once per tick, after they have settled. Sits between the host/control interface and the `redstone` module.

Parameters:
PERIOD, 5000000, system-clock cycles per redstone tick (10 Hz at 50 MHz); must be >= HIGH_CYC+2
HIGH_CYC, 2500000, cycles `o_tick` is held high per tick
NUM_IO, 10, width of the input and output vectors
CNT_W, 32, width of the `o_tick_count` counter

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_mode  in  2  0=STOP, 1=RUN (free-running), 2=STEP, 3=reserved (treated as STOP)
i_step_req  in  1  one-cycle pulse; starts a STEP burst when idle in STEP mode
i_step_n  in  16  number of ticks in a STEP burst
i_inputs  in  NUM_IO  raw external inputs
o_inputs  out  NUM_IO  latched inputs driven into `redstone.inputs`
i_outputs  in  NUM_IO  `redstone.outputs`
o_outputs  out  NUM_IO  outputs captured once per tick
o_tick  out  1  registered tick, drives `redstone.tick`
o_busy  out  1  high while a tick or burst is in progress
o_done  out  1  one-cycle pulse at the end of a STEP burst
o_tick_count  out  CNT_W  total rising edges issued, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync release): all outputs are 0 and the FSM is in IDLE. The cycle and step counters are cleared.
- FSM states: IDLE, SETUP, HIGH, LOW.
- IDLE: `o_tick`=0 and `o_busy`=0.
  - RUN → SETUP.
  - STEP with `i_step_req`=1: latch `i_step_n` into `steps_left`.
    - If it is 0: pulse `o_done` on the next cycle and stay in IDLE.
    - Otherwise → SETUP.
  - `i_step_req` is ignored outside IDLE and outside STEP mode.
- SETUP (exactly 1 cycle): `o_inputs` <= `i_inputs`, `o_tick`=0.
  - Next state is HIGH, and `o_tick` rises on entry.
  - `o_tick_count` increments on that same edge.
- HIGH: `o_tick`=1 for exactly HIGH_CYC cycles → LOW.
- LOW: `o_tick`=0 for PERIOD-HIGH_CYC-1 cycles.
  - In the last LOW cycle, `o_outputs` <= `i_outputs`.
  - In STEP mode, `steps_left` decrements in the last LOW cycle. If it reaches 0: `o_done`=1 for one cycle and the next state is IDLE.
  - In RUN mode: next state is SETUP.
  - In STOP mode: next state is IDLE.
- Tick period = PERIOD cycles exactly: SETUP 1 + HIGH HIGH_CYC + LOW rest.
- `o_inputs` never changes while `o_tick`=1.
- `o_busy`=1 in SETUP, HIGH and LOW.
- Mode change mid-tick never truncates a tick. The current tick completes, and the mode is sampled only in the last LOW cycle and in IDLE.
  - RUN→STEP mid-tick: end after the current tick and go to IDLE; no `o_done`.
  - STEP→RUN mid-burst: continue free-running; the burst is abandoned and no `o_done` is issued.
- `o_tick_count` wraps from all-ones to 0 silently.
- Reset mid-tick: `o_tick` drops immediately (async) and all state clears. `o_done` is not issued.

Decomposition:
- Shared package `redstone_pkg`:
  - `mode_e` enum (STOP, RUN, STEP).
  - `seq_state_e` enum (IDLE, SETUP, HIGH, LOW).
  - Default PERIOD/HIGH_CYC constants for a 50 MHz board.
- One sub-module, `tick_timer`: loadable down-counter of width $clog2(PERIOD) with `load`, `load_val` and `zero` flag. It is instantiated once and reloaded on each state entry.
- The top holds the FSM, step counter, I/O latches and tick counter.

Test Plan:
All scenarios use PERIOD=8 and HIGH_CYC=3.
- Reset release, `i_mode`=STOP for 20 cycles → `o_tick`=0, `o_busy`=0, `o_tick_count`=0, `o_done`=0 throughout.
- `i_mode`=RUN for 40 cycles → 5 rising edges exactly 8 cycles apart. Each high phase lasts 3 cycles. `o_tick_count`=5.
- STEP, `i_step_n`=3, pulse `i_step_req` → 3 ticks, then one `o_done` pulse 7 cycles after the third rise. Then IDLE and `o_busy`=0. A second `i_step_req` sent while busy is ignored.
- STEP burst with `i_step_n`=0 → `o_done` the next cycle, no tick, count unchanged.
- `i_inputs` toggles every cycle in RUN → `o_inputs` changes only on the SETUP→HIGH edge. `o_outputs` equals the `i_outputs` value sampled in the last LOW cycle (e.g. `i_outputs`=10'h2A3 at that cycle → `o_outputs`=10'h2A3).
- RUN, switch to STOP 1 cycle after a rise → the high phase still lasts 3 cycles, the tick completes, then IDLE.
- RUN, assert `i_rst_n`=0 mid-HIGH → `o_tick`=0 immediately. After release, `o_tick_count`=0.
